// File: rtl/defines_package.sv
// Shared types and constants for the line clipper: endpoint struct, outcode bits,
// window limits and clipper state encoding.
package defines_package;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } Point2D;

   localparam logic [3:0] INSIDE = 4'b0000;
   localparam logic [3:0] LEFT   = 4'b0001;
   localparam logic [3:0] RIGHT  = 4'b0010;
   localparam logic [3:0] BOTTOM = 4'b0100;
   localparam logic [3:0] TOP    = 4'b1000;

   localparam logic signed [15:0] XMIN = 16'sd0;
   localparam logic signed [15:0] XMAX = 16'sd640;
   localparam logic signed [15:0] YMIN = 16'sd0;
   localparam logic signed [15:0] YMAX = 16'sd480;

   typedef enum logic [2:0] {
      IDLE,
      CODE,
      SETUP,
      DIV,
      UPDATE,
      OUT
   } clip_state_t;

endpackage

// File: rtl/outcode.sv
// Cohen-Sutherland region code of one point against the fixed clip window.
module outcode
   import defines_package::*;
(
   input  Point2D     p,
   output logic [3:0] code
);

   always_comb begin
      code = INSIDE;
      if (p.x < XMIN) code = code | LEFT;
      if (p.x > XMAX) code = code | RIGHT;
      if (p.y < YMIN) code = code | BOTTOM;
      if (p.y > YMAX) code = code | TOP;
   end

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses once the
// full quotient is available, NUM_W cycles after start.
module seq_divider #(
   parameter int NUM_W = 34,
   parameter int DEN_W = 17
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [NUM_W-1:0] dividend,
   input  logic [DEN_W-1:0] divisor,
   output logic [NUM_W-1:0] quotient,
   output logic             done
);

   localparam int CW = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] rem, den_r, src_rem, src_den, step_rem;
   logic [NUM_W-1:0] quo, src_quo, step_quo;
   logic [DEN_W:0]   trial, diff;
   logic [CW-1:0]    cnt;
   logic             busy;

   // The first step runs on the start edge itself, straight from the operands.
   always_comb begin
      src_rem = start ? '0 : rem;
      src_quo = start ? dividend : quo;
      src_den = start ? divisor : den_r;
      trial   = {src_rem, src_quo[NUM_W-1]};
      diff    = trial - {1'b0, src_den};
      if (trial >= {1'b0, src_den}) begin
         step_rem = diff[DEN_W-1:0];
         step_quo = {src_quo[NUM_W-2:0], 1'b1};
      end else begin
         step_rem = trial[DEN_W-1:0];
         step_quo = {src_quo[NUM_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rem   <= '0;
         quo   <= '0;
         den_r <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem   <= step_rem;
            quo   <= step_quo;
            den_r <= divisor;
            cnt   <= CW'(NUM_W - 1);
            busy  <= 1'b1;
         end else if (busy) begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/line_clipper.sv
// Sequential Cohen-Sutherland clipper against [0,640]x[0,480]: trivial accept,
// trivial reject, or iterative edge clipping through a shared divider.
module line_clipper
   import defines_package::*;
#(
   parameter int NUM_W    = 34,
   parameter int MAX_ITER = 4
) (
   input  logic   clk,
   input  logic   n_rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  Point2D in_p0,
   input  Point2D in_p1,
   output logic   out_valid,
   input  logic   out_ready,
   output Point2D out_p0,
   output Point2D out_p1,
   output logic   rejected
);

   clip_state_t state, next_state;
   Point2D      p0, p1, pp, qq;
   logic [3:0]  c0, c1, pc;
   logic [7:0]  iter;
   logic        reject_c, sel_p0, y_edge, div_done;
   logic        sel_p0_r, y_edge_r, neg_r;

   logic signed [15:0]    edge_v, edge_r, base_r, step_v, new_c;
   logic signed [16:0]    span, off, den_s;
   logic signed [NUM_W-1:0] num_s;
   logic [NUM_W-1:0]      num_mag, div_quo;
   logic [16:0]           den_mag;

   outcode u_code0 (.p(p0), .code(c0));
   outcode u_code1 (.p(p1), .code(c1));

   assign reject_c = ((c0 & c1) != INSIDE) || (iter == 8'(MAX_ITER));

   // Edge selection and the signed num/den; the divider only sees magnitudes.
   always_comb begin
      sel_p0 = (c0 != INSIDE);
      pp     = sel_p0 ? p0 : p1;
      qq     = sel_p0 ? p1 : p0;
      pc     = sel_p0 ? c0 : c1;
      y_edge = ((pc & (TOP | BOTTOM)) != INSIDE);
      if ((pc & TOP) != INSIDE)         edge_v = YMAX;
      else if ((pc & BOTTOM) != INSIDE) edge_v = YMIN;
      else if ((pc & RIGHT) != INSIDE)  edge_v = XMAX;
      else                              edge_v = XMIN;
      if (y_edge) begin
         span  = $signed({qq.x[15], qq.x}) - $signed({pp.x[15], pp.x});
         off   = $signed({edge_v[15], edge_v}) - $signed({pp.y[15], pp.y});
         den_s = $signed({qq.y[15], qq.y}) - $signed({pp.y[15], pp.y});
      end else begin
         span  = $signed({qq.y[15], qq.y}) - $signed({pp.y[15], pp.y});
         off   = $signed({edge_v[15], edge_v}) - $signed({pp.x[15], pp.x});
         den_s = $signed({qq.x[15], qq.x}) - $signed({pp.x[15], pp.x});
      end
      num_s   = span * off;
      num_mag = num_s[NUM_W-1] ? NUM_W'(-num_s) : NUM_W'(num_s);
      den_mag = den_s[16] ? 17'(-den_s) : 17'(den_s);
   end

   seq_divider #(.NUM_W(NUM_W), .DEN_W(17)) u_div (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (state == SETUP),
      .dividend (num_mag),
      .divisor  (den_mag),
      .quotient (div_quo),
      .done     (div_done)
   );

   always_comb begin
      step_v = neg_r ? -$signed(div_quo[15:0]) : $signed(div_quo[15:0]);
      new_c  = base_r + step_v;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = CODE;
         CODE: begin
            if ((c0 | c1) == INSIDE) next_state = OUT;
            else if (reject_c)       next_state = IDLE;
            else                     next_state = SETUP;
         end
         SETUP:   next_state = DIV;
         DIV:     if (div_done) next_state = UPDATE;
         UPDATE:  next_state = CODE;
         OUT:     if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Endpoint registers double as the output registers; the clip result
   // overwrites whichever endpoint was outside.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         p0       <= '0;
         p1       <= '0;
         iter     <= '0;
         sel_p0_r <= 1'b0;
         y_edge_r <= 1'b0;
         neg_r    <= 1'b0;
         edge_r   <= '0;
         base_r   <= '0;
         rejected <= 1'b0;
      end else begin
         rejected <= (state == CODE) && ((c0 | c1) != INSIDE) && reject_c;
         if (state == IDLE && in_valid) begin
            p0   <= in_p0;
            p1   <= in_p1;
            iter <= '0;
         end
         if (state == SETUP) begin
            sel_p0_r <= sel_p0;
            y_edge_r <= y_edge;
            edge_r   <= edge_v;
            base_r   <= y_edge ? pp.x : pp.y;
            neg_r    <= num_s[NUM_W-1] ^ den_s[16];
         end
         if (state == UPDATE) begin
            iter <= iter + 8'd1;
            if (sel_p0_r) begin
               p0.x <= y_edge_r ? new_c : edge_r;
               p0.y <= y_edge_r ? edge_r : new_c;
            end else begin
               p1.x <= y_edge_r ? new_c : edge_r;
               p1.y <= y_edge_r ? edge_r : new_c;
            end
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign out_p0    = p0;
   assign out_p1    = p1;

endmodule

// File: tb/tb_line_clipper.sv
// Directed bench for line_clipper: hand-computed endpoints, latencies,
// backpressure and mid-divide reset.
module tb_line_clipper;
   import defines_package::*;

   logic   clk = 1'b0;
   logic   n_rst;
   logic   in_valid, in_ready, out_valid, out_ready, rejected;
   Point2D in_p0, in_p1, out_p0, out_p1;

   int vectors = 0;
   int miscompares = 0;
   int lat;
   bit seen;

   line_clipper #(.NUM_W(34), .MAX_ITER(4)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p0     (in_p0),
      .in_p1     (in_p1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p0    (out_p0),
      .out_p1    (out_p1),
      .rejected  (rejected)
   );

   always #5 clk = ~clk;

   function automatic Point2D pt(input int x, input int y);
      Point2D r;
      r.x = 16'(x);
      r.y = 16'(y);
      return r;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input Point2D a, input Point2D b);
      @(negedge clk);
      in_valid = 1'b1;
      in_p0    = a;
      in_p1    = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Latency counts cycles after the accepting cycle; bounded so a hung DUT still ends.
   task automatic wait_result(output int cycles);
      cycles = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid || rejected) break;
         @(posedge clk);
         cycles++;
      end
   endtask

   task automatic check_seg(input string tag, input int exp_lat, input bit exp_rej,
                            input Point2D e0, input Point2D e1);
      int l;
      wait_result(l);
      check_output({tag, " latency"}, 64'(l), 64'(exp_lat));
      check_output({tag, " out_valid"}, 64'(out_valid), 64'(!exp_rej));
      check_output({tag, " rejected"}, 64'(rejected), 64'(exp_rej));
      if (exp_rej) begin
         check_output({tag, " in_ready"}, 64'(in_ready), 64'd1);
      end else begin
         check_output({tag, " p0"}, 64'(out_p0), 64'(e0));
         check_output({tag, " p1"}, 64'(out_p1), 64'(e1));
      end
      @(posedge clk);
   endtask

   initial begin
      n_rst     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_p0     = '0;
      in_p1     = '0;
      #12;
      check_output("reset in_ready", 64'(in_ready), 64'd1);
      check_output("reset out_valid", 64'(out_valid), 64'd0);
      check_output("reset rejected", 64'(rejected), 64'd0);
      check_output("reset points", {out_p0, out_p1}, 64'd0);
      @(negedge clk);
      n_rst = 1'b1;

      apply_stimulus(pt(100, 100), pt(200, 300));
      check_seg("inside", 2, 1'b0, pt(100, 100), pt(200, 300));

      apply_stimulus(pt(-10, -10), pt(-5, 500));
      check_seg("trivial reject", 2, 1'b1, pt(0, 0), pt(0, 0));
      @(negedge clk);
      check_output("after reject out_valid", 64'(out_valid), 64'd0);

      apply_stimulus(pt(-100, 240), pt(320, 240));
      check_seg("single clip", 39, 1'b0, pt(0, 240), pt(320, 240));

      apply_stimulus(pt(320, -240), pt(320, 720));
      check_seg("double clip", 76, 1'b0, pt(320, 0), pt(320, 480));

      apply_stimulus(pt(-10, 0), pt(10, 10));
      check_seg("trunc 100/20", 39, 1'b0, pt(0, 5), pt(10, 10));

      apply_stimulus(pt(-3, 0), pt(4, 1));
      check_seg("trunc 3/7", 39, 1'b0, pt(0, 0), pt(4, 1));

      apply_stimulus(pt(-10, 10), pt(10, 0));
      check_seg("negative num", 39, 1'b0, pt(0, 5), pt(10, 0));

      apply_stimulus(pt(0, 470), pt(10, 500));
      check_seg("negative den", 39, 1'b0, pt(0, 470), pt(4, 480));

      apply_stimulus(pt(-10, 5), pt(5, -10));
      check_seg("reject after clip", 39, 1'b1, pt(0, 0), pt(0, 0));

      out_ready = 1'b0;
      apply_stimulus(pt(10, 20), pt(30, 40));
      wait_result(lat);
      check_output("bp latency", 64'(lat), 64'd2);
      for (int i = 0; i < 5; i++) begin
         check_output("bp out_valid", 64'(out_valid), 64'd1);
         check_output("bp in_ready", 64'(in_ready), 64'd0);
         check_output("bp points", {out_p0, out_p1}, {pt(10, 20), pt(30, 40)});
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_output("bp release in_ready", 64'(in_ready), 64'd1);
      check_output("bp release out_valid", 64'(out_valid), 64'd0);

      apply_stimulus(pt(-100, 240), pt(320, 240));
      repeat (10) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_output("mid-div reset in_ready", 64'(in_ready), 64'd1);
      check_output("mid-div reset out_valid", 64'(out_valid), 64'd0);
      check_output("mid-div reset rejected", 64'(rejected), 64'd0);
      check_output("mid-div reset points", {out_p0, out_p1}, 64'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid || rejected) seen = 1'b1;
      end
      check_output("no output after reset", 64'(seen), 64'd0);
      check_output("idle after reset", 64'(in_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
